board_setup_ctrl: RTL and testbench

//  Owner of the single write port into the top-level 32-square board register.
//  On a new-game request it shuffles the 32 banqi pieces with an LFSR (Fisher-Yates, rejection sampling)
//  and writes each one face-down to squares 31..0. While idle it forwards game-logic writes to the board.

---
 rtl/board_setup_ctrl.sv | 157 +++++++++++++++
 tb/tb_board_setup_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/board_setup_ctrl.sv
// Board write-port owner: forwards game-logic writes while idle and deals a shuffled, face-down
// banqi set into squares 31..0 on start. Optional macro SETUP_SEED_PORT_EN adds a seed input.
module board_setup_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       game_we,
  input  logic [4:0] game_addr,
  input  logic [4:0] game_piece,
`ifdef SETUP_SEED_PORT_EN
  input  logic [15:0] seed,
`endif
  output logic       board_we,
  output logic [4:0] board_addr,
  output logic [4:0] board_piece,
  output logic       busy,
  output logic       game_hold,
  output logic       done
);

  localparam int unsigned SQ_W   = 5;
  localparam int unsigned PC_W   = 5;
  localparam int unsigned POOL_W = 4;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned N_SQ   = 32;
  localparam logic [LFSR_W-1:0] SEED_DEF  = 16'hACE1;
  localparam logic [LFSR_W-1:0] SEED_INIT = (LFSR_SEED == '0) ? SEED_DEF : LFSR_SEED;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, WRITE, DONE} state_t;

  state_t             state, state_nx;
  logic [SQ_W-1:0]    idx, idx_nx;
  logic [SQ_W-1:0]    j, j_nx;
  logic [LFSR_W-1:0]  lfsr, lfsr_nx;
  logic [POOL_W-1:0]  pool [N_SQ];
  logic               board_we_nx, busy_nx, done_nx;
  logic [SQ_W-1:0]    board_addr_nx;
  logic [PC_W-1:0]    board_piece_nx;
  logic [SQ_W-1:0]    r;
  logic               fb;

  // Canonical {color,type} for pool slot i: red 0..15, black 16..31.
  function automatic logic [POOL_W-1:0] canon(input logic [SQ_W-1:0] i);
    logic [2:0] t;
    case (i[3:0])
      4'd0:          t = 3'b111;
      4'd1, 4'd2:    t = 3'b110;
      4'd3, 4'd4:    t = 3'b101;
      4'd5, 4'd6:    t = 3'b100;
      4'd7, 4'd8:    t = 3'b011;
      4'd9, 4'd10:   t = 3'b010;
      default:       t = 3'b001;
    endcase
    return {i[4], t};
  endfunction

  // Smallest all-ones mask covering idx keeps the rejection rate below one half.
  function automatic logic [SQ_W-1:0] mask_of(input logic [SQ_W-1:0] v);
    if (v >= 5'd16)     return 5'd31;
    else if (v >= 5'd8) return 5'd15;
    else if (v >= 5'd4) return 5'd7;
    else if (v >= 5'd2) return 5'd3;
    else if (v == 5'd1) return 5'd1;
    else                return 5'd0;
  endfunction

  assign r  = lfsr[SQ_W-1:0] & mask_of(idx);
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      idx         <= '0;
      j           <= '0;
      lfsr        <= SEED_INIT;
      board_we    <= 1'b0;
      board_addr  <= '0;
      board_piece <= '0;
      busy        <= 1'b0;
      game_hold   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      j           <= j_nx;
      lfsr        <= lfsr_nx;
      board_we    <= board_we_nx;
      board_addr  <= board_addr_nx;
      board_piece <= board_piece_nx;
      busy        <= busy_nx;
      game_hold   <= busy_nx;
      done        <= done_nx;
    end
  end

  // Pool storage needs no reset: LOAD fully rewrites it before any read.
  always_ff @(posedge CLK) begin
    if (state == LOAD) begin
      for (int unsigned i = 0; i < N_SQ; i++) pool[i] <= canon(SQ_W'(i));
    end else if (state == WRITE) begin
      pool[j] <= pool[idx];
    end
  end

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    j_nx           = j;
    lfsr_nx        = lfsr;
    board_we_nx    = 1'b0;
    board_addr_nx  = board_addr;
    board_piece_nx = board_piece;
    done_nx        = 1'b0;
    case (state)
      IDLE: begin
        board_we_nx    = game_we;
        board_addr_nx  = game_addr;
        board_piece_nx = game_piece;
        if (start) begin
          state_nx = LOAD;
`ifdef SETUP_SEED_PORT_EN
          lfsr_nx = (seed == '0) ? SEED_DEF : seed;
`endif
        end
      end
      LOAD: begin
        idx_nx   = 5'd31;
        state_nx = DRAW;
      end
      DRAW: begin
        lfsr_nx = {lfsr[LFSR_W-2:0], fb};
        if (r <= idx) begin
          j_nx           = r;
          state_nx       = WRITE;
          board_we_nx    = 1'b1;
          board_addr_nx  = idx;
          board_piece_nx = {pool[r], 1'b0};
        end
      end
      WRITE: begin
        if (idx == '0) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          idx_nx   = idx - 5'd1;
          state_nx = DRAW;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == LOAD) || (state_nx == DRAW) || (state_nx == WRITE);
  end

endmodule

// File: tb/tb_board_setup_ctrl.sv
// Directed bench for board_setup_ctrl: forwarding, shuffle contents/order against a reference
// deal, mid-shuffle interference, reproducibility and mid-shuffle reset.
module tb_board_setup_ctrl;

  logic       CLK, RESET_N, start, game_we;
  logic [4:0] game_addr, game_piece;
  logic       board_we, busy, game_hold, done;
  logic [4:0] board_addr, board_piece;
`ifdef SETUP_SEED_PORT_EN
  logic [15:0] seed;
`endif

  board_setup_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .game_we(game_we),
    .game_addr(game_addr), .game_piece(game_piece),
`ifdef SETUP_SEED_PORT_EN
    .seed(seed),
`endif
    .board_we(board_we), .board_addr(board_addr), .board_piece(board_piece),
    .busy(busy), .game_hold(game_hold), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  logic [15:0] model_lfsr;
  logic [4:0]  exp_piece [32];
  logic [4:0]  cap [32];
  logic [4:0]  ref_cap [32];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] type_of(input int k);
    if (k == 0) return 3'd7;
    else if (k <= 10) return 3'(6 - (k - 1) / 2);
    else return 3'd1;
  endfunction

  function automatic int count_of(input int code);
    int t;
    t = code % 8;
    if (t == 7) return 1;
    else if (t == 1) return 5;
    else if (t == 0) return 0;
    else return 2;
  endfunction

  // Reference Fisher-Yates deal; advances model_lfsr exactly as one shuffle should.
  task automatic model_shuffle();
    logic [3:0] p [32];
    int m, rr, guard;
    for (int i = 0; i < 32; i++) p[i] = {1'(i >= 16), type_of(i % 16)};
    for (int idx = 31; idx >= 0; idx--) begin
      m = 0;
      while (m < idx) m = m * 2 + 1;
      guard = 0;
      do begin
        rr = int'(model_lfsr[4:0]) & m;
        model_lfsr = {model_lfsr[14:0], ^(model_lfsr & 16'hB400)};
        guard++;
      end while (rr > idx && guard < 1000);
      exp_piece[idx] = {p[rr], 1'b0};
      p[rr] = p[idx];
    end
  endtask

  task automatic prep_model();
`ifdef SETUP_SEED_PORT_EN
    model_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
`endif
    model_shuffle();
  endtask

  task automatic do_reset();
    @(negedge CLK) RESET_N = 1'b0;
    @(negedge CLK) RESET_N = 1'b1;
    model_lfsr = 16'hACE1;
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_we"},    32'(board_we),    32'd0);
    check_vec({tag, "_addr"},  32'(board_addr),  32'd0);
    check_vec({tag, "_piece"}, 32'(board_piece), 32'd0);
    check_vec({tag, "_busy"},  32'(busy),        32'd0);
    check_vec({tag, "_hold"},  32'(game_hold),   32'd0);
    check_vec({tag, "_done"},  32'(done),        32'd0);
  endtask

  // Start a shuffle and watch it; inj_at>0 pokes game_we/start after that many writes,
  // abort_at>0 drops RESET_N after that many writes.
  task automatic run_shuffle(input int inj_at, input int abort_at);
    int nwr, hist [16];
    bit seen_done;
    nwr = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 16; k++) hist[k] = 0;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    check_vec("busy_load", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      game_we = 1'b0;
      if (board_we) begin
        check_vec("wr_addr", 32'(board_addr), 32'(31 - nwr));
        if (nwr < 32) begin
          check_vec("wr_piece", 32'(board_piece), 32'(exp_piece[31 - nwr]));
          cap[31 - nwr] = board_piece;
        end
        check_vec("wr_hold", 32'(game_hold), 32'd1);
        hist[board_piece[4:1]]++;
        nwr++;
        if (nwr == inj_at) begin
          game_we = 1'b1; game_addr = 5'h03; game_piece = 5'h1F; start = 1'b1;
        end
        if (abort_at != 0 && nwr == abort_at) begin
          RESET_N = 1'b0;
          return;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check_vec("done_busy", 32'(busy), 32'd0);
        check_vec("done_hold", 32'(game_hold), 32'd0);
      end
    end
    check_vec("done_seen", 32'(seen_done), 32'd1);
    check_vec("write_count", 32'(nwr), 32'd32);
    @(negedge CLK);
    check_vec("done_once", 32'(done), 32'd0);
    check_vec("idle_we", 32'(board_we), 32'd0);
    for (int k = 0; k < 16; k++) check_vec($sformatf("hist_%0d", k), 32'(hist[k]), 32'(count_of(k)));
  endtask

  initial begin
    RESET_N = 1'b0; start = 1'b0; game_we = 1'b0; game_addr = '0; game_piece = '0;
`ifdef SETUP_SEED_PORT_EN
    seed = 16'h1234;
`endif
    model_lfsr = 16'hACE1;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    check_zero("reset");

    // Idle forwarding with one-cycle latency
    game_we = 1'b1; game_addr = 5'h0A; game_piece = 5'b1_100_1;
    @(negedge CLK) game_we = 1'b0;
    check_vec("fwd_we",    32'(board_we),    32'd1);
    check_vec("fwd_addr",  32'(board_addr),  32'h0A);
    check_vec("fwd_piece", 32'(board_piece), 32'h19);
    @(negedge CLK);
    check_vec("fwd_we_off", 32'(board_we), 32'd0);

    // First shuffle after reset, kept as reference
    prep_model();
    run_shuffle(0, 0);
    for (int i = 0; i < 32; i++) ref_cap[i] = cap[i];

    // Mid-shuffle game write and start are dropped
    prep_model();
    run_shuffle(5, 0);

    // Same starting state after reset gives the same deal
    do_reset();
    prep_model();
    run_shuffle(0, 0);
    for (int i = 0; i < 32; i++) check_vec($sformatf("repro_%0d", i), 32'(cap[i]), 32'(ref_cap[i]));

`ifdef SETUP_SEED_PORT_EN
    seed = 16'h0;
    prep_model();
    run_shuffle(0, 0);
    for (int i = 0; i < 32; i++) ref_cap[i] = cap[i];
    seed = 16'hACE1;
    prep_model();
    run_shuffle(0, 0);
    for (int i = 0; i < 32; i++) check_vec($sformatf("seed0_%0d", i), 32'(cap[i]), 32'(ref_cap[i]));
`endif

    // Reset after 10 writes, then a clean full shuffle
    prep_model();
    run_shuffle(0, 10);
    #1;
    check_zero("abort");
    @(negedge CLK);
    check_zero("abort_hold");
    RESET_N = 1'b1;
    model_lfsr = 16'hACE1;
    @(negedge CLK);
    prep_model();
    run_shuffle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
